// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and width helpers for the debounce bank.
//   clog2_min1  - ceil(log2(v)), never less than 1 (keeps 1-bit minimum vectors)
//   cnt_width   - stability counter width for a given STABLE_CYCLES
//   hold_width  - hold/repeat counter width for given delay and period
//   *_50MHZ     - default timing constants for a 50 MHz system clock
package debounce_pkg;

    localparam int unsigned DB_STABLE_50MHZ  = 40000;     // 0.8 ms
    localparam int unsigned RPT_DELAY_50MHZ  = 25000000;  // 0.5 s before first repeat
    localparam int unsigned RPT_PERIOD_50MHZ = 5000000;   // 0.1 s between repeats

    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned w;
        w = (v > 1) ? $clog2(v) : 1;
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return clog2_min1(stable_cycles);
    endfunction

    function automatic int unsigned hold_width(input int unsigned delay,
                                               input int unsigned period);
        int unsigned m;
        m = (delay > period) ? delay : period;
        return clog2_min1(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one debounced input.
//   clk, rst_n : system clock, synchronous active-low reset
//   in         : raw asynchronous input
//   level      : debounced level (registered)
//   press      : one-cycle strobe in the first cycle level reads 1
//   rel        : one-cycle strobe in the first cycle level reads 0
//                ("release" is a reserved word, hence the short name)
//   rpt        : one-cycle auto-repeat strobe while level is held high
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DB_STABLE_50MHZ,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = RPT_DELAY_50MHZ,
    parameter int unsigned REPEAT_PERIOD = RPT_PERIOD_50MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam int unsigned CW = cnt_width(STABLE_CYCLES);
    localparam int unsigned HW = hold_width(REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CW-1:0] CntMax    = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] DelayMax  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PeriodMax = HW'(REPEAT_PERIOD - 1);

    logic          s1_q, s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, rel_q;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          hphase_q, hphase_d;
    logic          rpt_q, rpt_d;

    // Stability filter: any agreeing sample restarts qualification.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            level_d = s_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Hold counter only runs while level was already high and stays high, so it
    // starts the cycle after press and is cleared on the same edge as a release.
    always_comb begin
        hcnt_d   = '0;
        hphase_d = 1'b0;
        rpt_d    = 1'b0;
        if (REPEAT_EN && level_q && level_d) begin
            if (!hphase_q && hcnt_q == DelayMax) begin
                rpt_d    = 1'b1;
                hphase_d = 1'b1;
            end else if (hphase_q && hcnt_q == PeriodMax) begin
                rpt_d    = 1'b1;
                hphase_d = 1'b1;
            end else begin
                hcnt_d   = hcnt_q + 1'b1;
                hphase_d = hphase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s_q      <= 1'b0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            hcnt_q   <= '0;
            hphase_q <= 1'b0;
            rpt_q    <= 1'b0;
        end else begin
            s1_q     <= in;
            s_q      <= s1_q;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            press_q  <= level_d & ~level_q;
            rel_q    <= ~level_d & level_q;
            hcnt_q   <= hcnt_d;
            hphase_q <= hphase_d;
            rpt_q    <= rpt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;
    assign rpt   = rpt_q;

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N independent debounce channels sharing one clock and reset.
//   clk, rst_n : system clock, synchronous active-low reset
//   in[N]      : raw asynchronous inputs, bit i = channel i
//   level[N]   : debounced levels
//   press[N]   : one-cycle rising strobes
//   rel[N]     : one-cycle falling (release) strobes
//   rpt[N]     : auto-repeat strobes, constant 0 unless REPEAT_EN
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N             = 4,
    parameter int unsigned STABLE_CYCLES = DB_STABLE_50MHZ,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = RPT_DELAY_50MHZ,
    parameter int unsigned REPEAT_PERIOD = RPT_PERIOD_50MHZ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] rpt
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .in   (in[i]),
            .level(level[i]),
            .press(press[i]),
            .rel  (rel[i]),
            .rpt  (rpt[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

    localparam int N  = 4;
    localparam int SC = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rpt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] din = '0;
    logic [N-1:0] level, press, rel, rpt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    exp_t exp_q[$];

    // Reference model: raw samples pass through a two-deep sample history;
    // run[c] counts consecutive samples disagreeing with the accepted level;
    // held[c] counts cycles since the press that started the current high.
    bit m_s1[N], m_s[N], m_lvl[N];
    int run[N], held[N];

    debounce_bank #(
        .N            (N),
        .STABLE_CYCLES(SC),
        .REPEAT_EN    (1'b1),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (din),
        .level(level),
        .press(press),
        .rel  (rel),
        .rpt  (rpt)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic [N-1:0] v, output exp_t e);
        e = '0;
        for (int c = 0; c < N; c++) begin
            if (!r) begin
                m_s1[c] = 1'b0; m_s[c] = 1'b0; m_lvl[c] = 1'b0;
                run[c] = 0; held[c] = 0;
            end else begin
                bit nl;
                nl = m_lvl[c];
                if (m_s[c] == m_lvl[c]) run[c] = 0;
                else begin
                    run[c]++;
                    if (run[c] == SC) begin nl = m_s[c]; run[c] = 0; end
                end
                m_s[c]  = m_s1[c];
                m_s1[c] = v[c];
                e.press[c] = nl & ~m_lvl[c];
                e.rel[c]   = ~nl & m_lvl[c];
                if (nl && m_lvl[c]) held[c]++;
                else held[c] = 0;
                e.rpt[c] = nl && m_lvl[c] && held[c] >= RD && ((held[c] - RD) % RP == 0);
                m_lvl[c]   = nl;
                e.level[c] = nl;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] v, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_n = r;
            din   = v;
            model_step(r, v, e);
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b want %b", name, cyc, act, want);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("level", level, e.level);
                check("press", press, e.press);
                check("release", rel, e.rel);
                check("rpt", rpt, e.rpt);
            end
        end
    end

    initial begin
        logic [N-1:0] base, v;
        // Reset with all inputs high, then qualification from scratch.
        drive(1'b0, 4'b1111, 3);
        drive(1'b1, 4'b1111, 8);
        // Return to all-low.
        drive(1'b1, 4'b0000, 8);
        // Glitch on channel 0.
        drive(1'b1, 4'b0001, 3);
        drive(1'b1, 4'b0000, 1);
        drive(1'b1, 4'b0001, 8);
        // Channel 1 high then release.
        drive(1'b1, 4'b0011, 8);
        drive(1'b1, 4'b0001, 8);
        // Channel 2 auto-repeat, then release.
        drive(1'b1, 4'b0101, 30);
        drive(1'b1, 4'b0001, 12);
        // Channel 3 high, then raise 0... from a low channel 0 with channel 3 falling.
        drive(1'b1, 4'b1000, 8);
        drive(1'b1, 4'b0001, 8);
        // Mid-repeat reset.
        drive(1'b1, 4'b0100, 18);
        drive(1'b0, 4'b0100, 1);
        drive(1'b1, 4'b0100, 10);
        // Randomised phase: slow level changes, short glitches, rare resets.
        base = 4'b0100;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 11) == 0) base[c] = ~base[c];
                v[c] = base[c] ^ ($urandom_range(0, 24) == 0);
            end
            drive(($urandom_range(0, 399) != 0), v, 1);
        end
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
